// File: rtl/adc_buffer_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared constants and state encoding for the ADC buffer
//                readout streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int c_data_width  = 12;
    localparam int c_addr_width  = 12;
    localparam int c_num_samples = 4096;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_buffer_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_buffer_streamer_if
//  Description : Valid/ready sample stream with an end-of-record marker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_buffer_streamer_if
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/adc_buffer_streamer_stream_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_buffer
//  Description : Two-entry valid/ready FIFO with registered head outputs,
//                occupancy report and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_flush,
    input  wire logic                  i_push,
    input  wire logic [DATA_WIDTH-1:0] i_push_data,
    output logic      [DATA_WIDTH-1:0] o_data,
    output logic                       o_valid,
    input  wire logic                  i_ready,
    output logic      [1:0]            o_occupancy
);
    logic [DATA_WIDTH-1:0] r_head_data;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_head_valid;
    logic                  r_tail_valid;
    logic                  w_pop;

    // The tail entry is only ever occupied while the head is occupied.
    assign w_pop       = r_head_valid && i_ready;
    assign o_data      = r_head_data;
    assign o_valid     = r_head_valid;
    assign o_occupancy = {1'b0, r_head_valid} + {1'b0, r_tail_valid};

    // Head/tail update: head refills from tail first, otherwise from the push.
    // The producer never pushes into a full buffer that is not popping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data  <= '0;
            r_tail_data  <= '0;
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
        end else if (i_flush) begin
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
        end else if (!r_head_valid || w_pop) begin
            if (r_tail_valid) begin
                r_head_data  <= r_tail_data;
                r_head_valid <= 1'b1;
                r_tail_data  <= i_push_data;
                r_tail_valid <= i_push;
            end else begin
                if (i_push) begin
                    r_head_data <= i_push_data;
                end
                r_head_valid <= i_push;
            end
        end else if (i_push) begin
            r_tail_data  <= i_push_data;
            r_tail_valid <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/adc_buffer_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_buffer_streamer
//  Description : Walks the capture buffer read port 0..NUM_SAMPLES-1 after a
//                completed capture and streams each sample with backpressure,
//                hiding the one-cycle read latency behind a skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_buffer_streamer
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width,
    parameter int ADDR_WIDTH  = c_addr_width,
    parameter int NUM_SAMPLES = c_num_samples
) (
    input  wire logic                  adc_clock,
    input  wire logic                  reset_n,
    input  wire logic                  capture_done,
    input  wire logic                  start_readout,
    input  wire logic                  abort,
    output logic      [ADDR_WIDTH-1:0] read_addr,
    input  wire logic [DATA_WIDTH-1:0] read_data,
    adc_buffer_streamer_if.master      stream,
    output logic                       busy,
    output logic                       readout_done
);
    // Counters carry one extra bit so a full 2^ADDR_WIDTH record never wraps.
    localparam logic [ADDR_WIDTH:0] c_END_PTR   = (ADDR_WIDTH+1)'(NUM_SAMPLES);
    localparam logic [ADDR_WIDTH:0] c_LAST_BEAT = (ADDR_WIDTH+1)'(NUM_SAMPLES - 1);
    localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_beat;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic                  w_skid_valid;
    logic [1:0]            w_occupancy;
    logic [2:0]            w_committed;
    logic                  w_streaming;
    logic                  w_start;
    logic                  w_flush;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic                  w_last_xfer;
    logic                  w_issue;

    assign w_streaming = (r_state == STREAM);
    assign w_start     = (r_state == IDLE) && start_readout && capture_done;
    assign w_flush     = w_streaming && abort;
    assign w_xfer      = w_skid_valid && stream.m_ready;
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_last_xfer = w_xfer && w_last_beat;

    // Slots already spoken for after this cycle's pop. Counting the pop lets a
    // new read go out every cycle in steady state instead of every other one.
    assign w_committed = {1'b0, w_occupancy} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_issue     = w_streaming && !abort && (r_rd_ptr < c_END_PTR)
                         && (w_committed < 3'd2);

    assign read_addr      = r_rd_ptr[ADDR_WIDTH-1:0];
    assign stream.m_data  = w_skid_data;
    assign stream.m_valid = w_skid_valid;
    assign stream.m_last  = w_skid_valid && w_last_beat;
    assign busy           = (r_state != IDLE);
    assign readout_done   = w_last_xfer && !abort;

    // State register.
    always_ff @(posedge adc_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: abort and the final transfer both end the readout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_readout && capture_done) w_next_state = STREAM;
            STREAM:  if (abort || w_last_xfer)          w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read pointer, beat counter and the one-deep in-flight read tracker.
    always_ff @(posedge adc_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_beat     <= '0;
            r_inflight <= 1'b0;
        end else if (w_start) begin
            r_rd_ptr   <= '0;
            r_beat     <= '0;
            r_inflight <= 1'b0;
        end else if (w_flush) begin
            r_inflight <= 1'b0;
        end else if (w_streaming) begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            if (w_xfer) begin
                r_beat <= r_beat + c_ONE;
            end
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (adc_clock),
        .rst_n       (reset_n),
        .i_flush     (w_flush),
        .i_push      (r_inflight),
        .i_push_data (read_data),
        .o_data      (w_skid_data),
        .o_valid     (w_skid_valid),
        .i_ready     (stream.m_ready),
        .o_occupancy (w_occupancy)
    );
endmodule
`default_nettype wire
